// File: rtl/foo_pipe_pkg.sv
// Shared types, defaults and reference functions for the elastic foo pipeline.
// Functions work on MAX_WIDTH-bit words; callers truncate to their own WIDTH.
package foo_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_NUM_STAGES = 2;
    localparam int unsigned MAX_WIDTH          = 64;
    localparam int unsigned PERF_W             = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // One compute stage: even stages add 1, odd stages bump the upper bits (adds 2).
    function automatic word_t stage_fn(input int j, input word_t d);
        if (j[0] == 1'b0) begin
            return d + word_t'(1);
        end
        return {d[MAX_WIDTH-1:1] + (MAX_WIDTH-1)'(1), d[0]};
    endfunction

    // Closed-form result of n chained stages.
    function automatic word_t expected_result(input word_t x, input int unsigned n);
        return x + word_t'((n + 1) / 2) + word_t'(2 * (n / 2));
    endfunction

endpackage

// File: rtl/foo_pipe_slot.sv
// One pipeline slot: {data, valid} register that loads when ready, holds otherwise.
module foo_pipe_slot
    import foo_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
        end
    end

    // Data is never reset; only the valid bit qualifies it.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/foo_pipe.sv
// Elastic valid/ready foo pipeline: input register plus NUM_STAGES compute slots.
// Optional FOO_PIPE_PERF_EN adds stall_cycles / xfer_count performance counters.
module foo_pipe
    import foo_pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] out,
    output logic             output_valid,
    input  logic             output_ready
`ifdef FOO_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] xfer_count
`endif
);

    logic             w_valid    [NUM_STAGES+1];
    logic [WIDTH-1:0] w_data     [NUM_STAGES+1];
    logic             w_rdy      [NUM_STAGES+1];
    logic             w_up_valid [NUM_STAGES+1];
    logic [WIDTH-1:0] w_up_data  [NUM_STAGES+1];

    // Ready ripples back from the consumer; an empty slot is always ready.
    always_comb begin
        w_rdy = '{default: 1'b0};
        for (int k = int'(NUM_STAGES); k >= 0; k--) begin
            if (k == int'(NUM_STAGES)) begin
                w_rdy[k] = !w_valid[k] || output_ready;
            end else begin
                w_rdy[k] = !w_valid[k] || w_rdy[k+1];
            end
        end
    end

    assign w_up_valid[0] = input_valid;
    assign w_up_data[0]  = x;

    for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stage
        assign w_up_valid[k] = w_valid[k-1];
        assign w_up_data[k]  = WIDTH'(stage_fn(k - 1, word_t'(w_data[k-1])));
    end

    for (genvar k = 0; k <= NUM_STAGES; k++) begin : g_slot
        foo_pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_load  (w_rdy[k]),
            .i_valid (w_up_valid[k]),
            .i_data  (w_up_data[k]),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k])
        );
    end

    assign input_ready  = w_rdy[0];
    assign out          = w_data[NUM_STAGES];
    assign output_valid = w_valid[NUM_STAGES];

`ifdef FOO_PIPE_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_xfer_count;

    // Stall counter saturates; handshake counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_xfer_count   <= '0;
        end else begin
            if (output_valid && !output_ready && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
            if (output_valid && output_ready) begin
                r_xfer_count <= r_xfer_count + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign xfer_count   = r_xfer_count;
`endif

endmodule

// File: tb/tb_foo_pipe.sv
// Directed + random bench for foo_pipe with a queue scoreboard on the default instance.
module tb_foo_pipe;
    import foo_pipe_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 2;
    localparam int unsigned W2 = 8;
    localparam int unsigned N2 = 5;

    logic          clk;
    logic          rst;
    logic          iv, ir, ov, ordy;
    logic [W-1:0]  x, out;
    logic          iv2, ir2, ov2, or2;
    logic [W2-1:0] x2, out2;
`ifdef FOO_PIPE_PERF_EN
    logic [31:0]   stall_cycles, xfer_count;
`endif

    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_tx, n_rx;
    word_t sb[$];

    foo_pipe #(.WIDTH(W), .NUM_STAGES(N)) dut (
        .clk(clk), .rst(rst), .input_valid(iv), .input_ready(ir), .x(x),
        .out(out), .output_valid(ov), .output_ready(ordy)
`ifdef FOO_PIPE_PERF_EN
        , .stall_cycles(stall_cycles), .xfer_count(xfer_count)
`endif
    );

    foo_pipe #(.WIDTH(W2), .NUM_STAGES(N2)) dut2 (
        .clk(clk), .rst(rst), .input_valid(iv2), .input_ready(ir2), .x(x2),
        .out(out2), .output_valid(ov2), .output_ready(or2)
`ifdef FOO_PIPE_PERF_EN
        , .stall_cycles(), .xfer_count()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the handshakes about to happen, then advance one clock to the next negedge.
    task automatic tick();
        word_t exp;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (iv && ir) begin
                sb.push_back(word_t'(W'(expected_result(word_t'(x), N))));
                n_tx++;
            end
            if (ov && ordy) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", word_t'(ov), word_t'(0));
                end else begin
                    exp = sb.pop_front();
                    check("sb_out", word_t'(out), exp);
                    n_rx++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n_hi;
        int lat;
        int budget;
        rst = 1'b1; iv = 1'b0; x = '0; ordy = 1'b1;
        iv2 = 1'b0; x2 = '0; or2 = 1'b1;
        n_tx = 0; n_rx = 0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        check("rst_output_valid", word_t'(ov), word_t'(0));
        check("rst_input_ready", word_t'(ir), word_t'(1));
        check("rst_output_valid_w8", word_t'(ov2), word_t'(0));

        // 1: x=0,1,2 back to back; results 3,4,5 on cycles 3,4,5
        iv = 1'b1; x = 32'd0;
        tick();
        n_hi = 0;
        for (int c = 1; c <= 8; c++) begin
            check("t1_valid_timing", word_t'(ov), word_t'(c >= 3 && c <= 5));
            if (ov) begin
                n_hi++;
                check("t1_out", word_t'(out), word_t'(c));
            end
            if (c <= 2) x = W'(c);
            else        iv = 1'b0;
            tick();
        end
        check("t1_valid_count", word_t'(n_hi), word_t'(3));

        // Overflow wraps
        iv = 1'b1; x = 32'hFFFF_FFFE;
        tick();
        iv = 1'b0;
        tick(); tick();
        check("wrap_valid", word_t'(ov), word_t'(1));
        check("wrap_out", word_t'(out), word_t'(32'h0000_0001));
        tick();

        // 2: fill three slots with the consumer stalled, then drain
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; x = W'(10 + i);
            check("t2_ready_filling", word_t'(ir), word_t'(1));
            tick();
        end
        iv = 1'b0;
        check("t2_full_ready", word_t'(ir), word_t'(0));
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", word_t'(ov), word_t'(1));
            check("t2_hold_out", word_t'(out), word_t'(13));
            check("t2_hold_ready", word_t'(ir), word_t'(0));
            tick();
        end
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_drain_nogap", word_t'(ov), word_t'(1));
            tick();
        end
        check("t2_drained", word_t'(ov), word_t'(0));
        check("t2_sb_empty", word_t'(sb.size()), word_t'(0));

        // 4: WIDTH=8, NUM_STAGES=5
        check("t4_ready", word_t'(ir2), word_t'(1));
        iv2 = 1'b1; x2 = 8'hF8;
        tick();
        iv2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 20) begin tick(); lat++; end
        check("t4_latency", word_t'(lat), word_t'(N2 + 1));
        check("t4_out_f8", word_t'(out2), word_t'(8'hFF));
        tick();
        iv2 = 1'b1; x2 = 8'hFC;
        tick();
        iv2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 20) begin tick(); lat++; end
        check("t4_out_fc_wrap", word_t'(out2), word_t'(8'h03));
        tick();

        // 5: reset with two items in flight
        ordy = 1'b1;
        iv = 1'b1; x = 32'd20;
        tick();
        x = 32'd21;
        tick();
        iv = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid_after_rst", word_t'(ov), word_t'(0));
        for (int i = 0; i < 4; i++) begin
            check("t5_flushed", word_t'(ov), word_t'(0));
            tick();
        end
        iv = 1'b1; x = 32'd7;
        tick();
        iv = 1'b0;
        tick(); tick();
        check("t5_valid", word_t'(ov), word_t'(1));
        check("t5_out", word_t'(out), word_t'(10));
        tick();

        // 3: random valid/ready, 10k items
        n_tx = 0; n_rx = 0; budget = 0;
        while ((n_tx < 10000 || sb.size() != 0) && budget < 60000) begin
            iv   = (n_tx < 10000) && ($urandom_range(0, 3) != 0);
            x    = W'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            tick();
            budget++;
        end
        iv = 1'b0; ordy = 1'b1;
        check("t3_within_budget", word_t'(budget < 60000), word_t'(1));
        check("t3_rx_count", word_t'(n_rx), word_t'(10000));
        check("t3_sb_empty", word_t'(sb.size()), word_t'(0));

`ifdef FOO_PIPE_PERF_EN
        // 6: performance counters
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_stall_rst", word_t'(stall_cycles), word_t'(0));
        check("t6_xfer_rst", word_t'(xfer_count), word_t'(0));
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1; x = W'(i + 1);
            tick();
        end
        iv = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ordy = 1'b0;
        check("t6_stall_cycles", word_t'(stall_cycles), word_t'(4));
        check("t6_xfer_count", word_t'(xfer_count), word_t'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_stall_clear", word_t'(stall_cycles), word_t'(0));
        check("t6_xfer_clear", word_t'(xfer_count), word_t'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
